// File: rtl/md5_block_core.sv
// Iterative MD5 compression for one 512-bit block: STEPS_PER_CYCLE rounds per clock
// through a combinational step chain, then an optional Davies-Meyer feed-forward.
module md5_block_core #(
  parameter int STEPS_PER_CYCLE = 1,
  parameter bit FINAL_ADD       = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [511:0] in_block,
  input  logic [127:0] in_chain,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int         S         = STEPS_PER_CYCLE;
  localparam logic [5:0] STEP_INC  = 6'(S);
  localparam logic [5:0] LAST_STEP = 6'(64 - S);

  generate
    if (S != 1 && S != 2 && S != 4 && S != 8 && S != 16) begin : g_bad_steps
      $error("md5_block_core: STEPS_PER_CYCLE must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  function automatic logic [31:0] md5_t(input logic [5:0] i);
    logic [31:0] t;
    t = '0;
    case (i)
      6'd0:  t = 32'hd76aa478; 6'd1:  t = 32'he8c7b756; 6'd2:  t = 32'h242070db; 6'd3:  t = 32'hc1bdceee;
      6'd4:  t = 32'hf57c0faf; 6'd5:  t = 32'h4787c62a; 6'd6:  t = 32'ha8304613; 6'd7:  t = 32'hfd469501;
      6'd8:  t = 32'h698098d8; 6'd9:  t = 32'h8b44f7af; 6'd10: t = 32'hffff5bb1; 6'd11: t = 32'h895cd7be;
      6'd12: t = 32'h6b901122; 6'd13: t = 32'hfd987193; 6'd14: t = 32'ha679438e; 6'd15: t = 32'h49b40821;
      6'd16: t = 32'hf61e2562; 6'd17: t = 32'hc040b340; 6'd18: t = 32'h265e5a51; 6'd19: t = 32'he9b6c7aa;
      6'd20: t = 32'hd62f105d; 6'd21: t = 32'h02441453; 6'd22: t = 32'hd8a1e681; 6'd23: t = 32'he7d3fbc8;
      6'd24: t = 32'h21e1cde6; 6'd25: t = 32'hc33707d6; 6'd26: t = 32'hf4d50d87; 6'd27: t = 32'h455a14ed;
      6'd28: t = 32'ha9e3e905; 6'd29: t = 32'hfcefa3f8; 6'd30: t = 32'h676f02d9; 6'd31: t = 32'h8d2a4c8a;
      6'd32: t = 32'hfffa3942; 6'd33: t = 32'h8771f681; 6'd34: t = 32'h6d9d6122; 6'd35: t = 32'hfde5380c;
      6'd36: t = 32'ha4beea44; 6'd37: t = 32'h4bdecfa9; 6'd38: t = 32'hf6bb4b60; 6'd39: t = 32'hbebfbc70;
      6'd40: t = 32'h289b7ec6; 6'd41: t = 32'heaa127fa; 6'd42: t = 32'hd4ef3085; 6'd43: t = 32'h04881d05;
      6'd44: t = 32'hd9d4d039; 6'd45: t = 32'he6db99e5; 6'd46: t = 32'h1fa27cf8; 6'd47: t = 32'hc4ac5665;
      6'd48: t = 32'hf4292244; 6'd49: t = 32'h432aff97; 6'd50: t = 32'hab9423a7; 6'd51: t = 32'hfc93a039;
      6'd52: t = 32'h655b59c3; 6'd53: t = 32'h8f0ccc92; 6'd54: t = 32'hffeff47d; 6'd55: t = 32'h85845dd1;
      6'd56: t = 32'h6fa87e4f; 6'd57: t = 32'hfe2ce6e0; 6'd58: t = 32'ha3014314; 6'd59: t = 32'h4e0811a1;
      6'd60: t = 32'hf7537e82; 6'd61: t = 32'hbd3af235; 6'd62: t = 32'h2ad7d2bb; 6'd63: t = 32'heb86d391;
    endcase
    return t;
  endfunction

  // Rotation amount depends only on the round and the step position within a group of four.
  function automatic logic [4:0] md5_s(input logic [5:0] i);
    logic [4:0] s;
    s = '0;
    case ({i[5:4], i[1:0]})
      4'h0: s = 5'd7;  4'h1: s = 5'd12; 4'h2: s = 5'd17; 4'h3: s = 5'd22;
      4'h4: s = 5'd5;  4'h5: s = 5'd9;  4'h6: s = 5'd14; 4'h7: s = 5'd20;
      4'h8: s = 5'd4;  4'h9: s = 5'd11; 4'ha: s = 5'd16; 4'hb: s = 5'd23;
      4'hc: s = 5'd6;  4'hd: s = 5'd10; 4'he: s = 5'd15; 4'hf: s = 5'd21;
    endcase
    return s;
  endfunction

  function automatic logic [31:0] rotl(input logic [31:0] x, input logic [4:0] s);
    return (x << s) | (x >> (6'd32 - {1'b0, s}));
  endfunction

  // One MD5 step on packed {D,C,B,A}; returns the rotated register set in the same packing.
  function automatic logic [127:0] md5_step(input logic [127:0] abcd, input logic [5:0] i,
                                            input logic [511:0] blk);
    logic [31:0] a, b, c, d, f, m, sum;
    logic [3:0]  g;
    a = abcd[31:0];
    b = abcd[63:32];
    c = abcd[95:64];
    d = abcd[127:96];
    f = '0;
    g = '0;
    case (i[5:4])
      2'd0: begin f = (b & c) | (~b & d); g = i[3:0]; end
      2'd1: begin f = (b & d) | (c & ~d); g = i[3:0] * 4'd5 + 4'd1; end
      2'd2: begin f = b ^ c ^ d;          g = i[3:0] * 4'd3 + 4'd5; end
      2'd3: begin f = c ^ (b | ~d);       g = i[3:0] * 4'd7; end
    endcase
    m   = blk[{g, 5'd0} +: 32];
    sum = a + f + m + md5_t(i);
    return {c, b, b + rotl(sum, md5_s(i)), d};
  endfunction

  function automatic logic [127:0] add_words(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] r;
    for (int w = 0; w < 4; w++) r[32*w +: 32] = x[32*w +: 32] + y[32*w +: 32];
    return r;
  endfunction

  state_t       state_q, state_d;
  logic [5:0]   step_q, step_d;
  logic [127:0] abcd_q, abcd_d;
  logic [127:0] chain_q, chain_d;
  logic [511:0] block_q, block_d;
  logic [127:0] out_state_q, out_state_d;
  logic         out_valid_q, out_valid_d;
  logic         busy_q, busy_d;
  logic [127:0] round_res;
  logic [127:0] final_res;

  // Combinational step chain: steps step_q .. step_q+S-1 in order
  always_comb begin
    round_res = abcd_q;
    for (int k = 0; k < S; k++) round_res = md5_step(round_res, step_q + 6'(k), block_q);
    final_res = FINAL_ADD ? add_words(chain_q, round_res) : round_res;
  end

  assign in_ready = (state_q == IDLE) && !reset;

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    abcd_d      = abcd_q;
    chain_d     = chain_q;
    block_d     = block_q;
    out_state_d = out_state_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          abcd_d  = in_chain;
          chain_d = in_chain;
          block_d = in_block;
          step_d  = '0;
          state_d = RUN;
          busy_d  = 1'b1;
        end
      end
      RUN: begin
        abcd_d = round_res;
        step_d = step_q + STEP_INC;
        if (step_q == LAST_STEP) begin
          out_state_d = final_res;
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
          busy_d      = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output state are reset; working data registers are not
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      step_q      <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      out_state_q <= '0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      out_state_q <= out_state_d;
    end
    abcd_q  <= abcd_d;
    chain_q <= chain_d;
    block_q <= block_d;
  end

  assign out_valid = out_valid_q;
  assign out_state = out_state_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_md5_block_core.sv
// Bench for md5_block_core: six instances covering STEPS_PER_CYCLE 1/2/4/8/16 and FINAL_ADD=0,
// driven with known MD5 vectors and random blocks checked against a behavioural MD5 model.
module tb_md5_block_core;

  localparam int NI = 6;
  localparam int S_TAB  [NI] = '{1, 4, 1, 2, 8, 16};
  localparam bit FA_TAB [NI] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};

  localparam logic [31:0] K_TAB [64] = '{
    32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee, 32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
    32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be, 32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
    32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa, 32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
    32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed, 32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
    32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c, 32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
    32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05, 32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
    32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039, 32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
    32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1, 32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391};

  localparam int R_TAB [64] = '{
    7, 12, 17, 22, 7, 12, 17, 22, 7, 12, 17, 22, 7, 12, 17, 22,
    5,  9, 14, 20, 5,  9, 14, 20, 5,  9, 14, 20, 5,  9, 14, 20,
    4, 11, 16, 23, 4, 11, 16, 23, 4, 11, 16, 23, 4, 11, 16, 23,
    6, 10, 15, 21, 6, 10, 15, 21, 6, 10, 15, 21, 6, 10, 15, 21};

  localparam logic [127:0] IV        = {32'h10325476, 32'h98badcfe, 32'hefcdab89, 32'h67452301};
  localparam logic [127:0] DIG_EMPTY = {32'h7e42f8ec, 32'h980980e9, 32'h04b2008f, 32'hd98c1dd4};
  localparam logic [127:0] DIG_ABC   = {32'h727fe128, 32'h7d3f96d6, 32'hb04fd23c, 32'h98500190};

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid  [NI];
  logic         in_ready  [NI];
  logic [511:0] in_block  [NI];
  logic [127:0] in_chain  [NI];
  logic         out_valid [NI];
  logic         out_ready [NI];
  logic [127:0] out_state [NI];
  logic         busy      [NI];

  logic [511:0] blk_empty;
  logic [511:0] blk_abc;
  int           n_checks = 0;
  int           n_fails  = 0;

  always #5 clk = ~clk;

  for (genvar j = 0; j < NI; j++) begin : g_dut
    md5_block_core #(.STEPS_PER_CYCLE(S_TAB[j]), .FINAL_ADD(FA_TAB[j])) u_dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid[j]),
      .in_ready  (in_ready[j]),
      .in_block  (in_block[j]),
      .in_chain  (in_chain[j]),
      .out_valid (out_valid[j]),
      .out_ready (out_ready[j]),
      .out_state (out_state[j]),
      .busy      (busy[j])
    );
  end

  function automatic logic [127:0] ref_md5(input logic [511:0] blk, input logic [127:0] chn, input bit fa);
    logic [31:0] a, b, c, d, f, tmp;
    logic [31:0] m [16];
    int g;
    for (int k = 0; k < 16; k++) m[k] = blk[32*k +: 32];
    a = chn[31:0]; b = chn[63:32]; c = chn[95:64]; d = chn[127:96];
    for (int i = 0; i < 64; i++) begin
      if (i < 16)      begin f = (b & c) | (~b & d); g = i; end
      else if (i < 32) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
      else if (i < 48) begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
      else             begin f = c ^ (b | ~d);       g = (7 * i) % 16; end
      tmp = a + f + K_TAB[i] + m[g];
      a = d; d = c; c = b;
      b = b + ((tmp << R_TAB[i]) | (tmp >> (32 - R_TAB[i])));
    end
    if (fa) return {chn[127:96] + d, chn[95:64] + c, chn[63:32] + b, chn[31:0] + a};
    return {d, c, b, a};
  endfunction

  task automatic send(input int id, input logic [511:0] blk, input logic [127:0] chn);
    int cnt = 0;
    while (!in_ready[id] && cnt < 300) begin @(posedge clk); #1; cnt++; end
    n_checks++;
    if (in_ready[id] !== 1'b1) begin
      n_fails++;
      $display("FAIL send_ready id=%0d: in_ready=%b, required 1", id, in_ready[id]);
    end
    in_valid[id] = 1'b1; in_block[id] = blk; in_chain[id] = chn;
    @(posedge clk); #1;
    in_valid[id] = 1'b0; in_block[id] = {16{$urandom}}; in_chain[id] = {4{$urandom}};
  endtask

  task automatic wait_out(input int id, output int lat);
    lat = 0;
    while (!out_valid[id] && lat < 200) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic release_out(input int id);
    out_ready[id] = 1'b1;
    @(posedge clk); #1;
    out_ready[id] = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    for (int j = 0; j < NI; j++) begin
      n_checks += 4;
      if (in_ready[j] !== 1'b0) begin n_fails++; $display("FAIL reset_in_ready id=%0d: got %b, required 0", j, in_ready[j]); end
      if (out_valid[j] !== 1'b0) begin n_fails++; $display("FAIL reset_out_valid id=%0d: got %b, required 0", j, out_valid[j]); end
      if (busy[j] !== 1'b0) begin n_fails++; $display("FAIL reset_busy id=%0d: got %b, required 0", j, busy[j]); end
      if (out_state[j] !== 128'd0) begin n_fails++; $display("FAIL reset_out_state id=%0d: got %h, required 0", j, out_state[j]); end
    end
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready[0] !== 1'b1) begin n_fails++; $display("FAIL reset_release_ready: got %b, required 1", in_ready[0]); end
  endtask

  task automatic test_empty_s1();
    int lat;
    send(0, blk_empty, IV);
    n_checks += 2;
    if (busy[0] !== 1'b1) begin n_fails++; $display("FAIL empty_busy: got %b, required 1", busy[0]); end
    if (in_ready[0] !== 1'b0) begin n_fails++; $display("FAIL empty_ready_run: got %b, required 0", in_ready[0]); end
    wait_out(0, lat);
    n_checks += 2;
    if (lat !== 64) begin n_fails++; $display("FAIL empty_latency: got %0d, required 64", lat); end
    if (out_state[0] !== DIG_EMPTY) begin n_fails++; $display("FAIL empty_digest: got %h, required %h", out_state[0], DIG_EMPTY); end
    out_ready[0] = 1'b1;
    #1;
    n_checks++;
    if (in_ready[0] !== 1'b0) begin n_fails++; $display("FAIL empty_no_turnaround: got %b, required 0", in_ready[0]); end
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    n_checks += 3;
    if (out_valid[0] !== 1'b0) begin n_fails++; $display("FAIL empty_out_valid_drop: got %b, required 0", out_valid[0]); end
    if (busy[0] !== 1'b0) begin n_fails++; $display("FAIL empty_busy_drop: got %b, required 0", busy[0]); end
    if (in_ready[0] !== 1'b1) begin n_fails++; $display("FAIL empty_ready_back: got %b, required 1", in_ready[0]); end
  endtask

  task automatic test_abc_s4();
    int lat;
    send(1, blk_abc, IV);
    wait_out(1, lat);
    n_checks += 2;
    if (lat !== 16) begin n_fails++; $display("FAIL abc_latency: got %0d, required 16", lat); end
    if (out_state[1] !== DIG_ABC) begin n_fails++; $display("FAIL abc_digest: got %h, required %h", out_state[1], DIG_ABC); end
    release_out(1);
  endtask

  task automatic test_backpressure();
    int lat;
    int bad = 0;
    send(1, blk_empty, IV);
    wait_out(1, lat);
    n_checks += 2;
    if (lat !== 16) begin n_fails++; $display("FAIL bp_latency: got %0d, required 16", lat); end
    if (out_state[1] !== DIG_EMPTY) begin n_fails++; $display("FAIL bp_digest: got %h, required %h", out_state[1], DIG_EMPTY); end
    in_valid[1] = 1'b1; in_block[1] = blk_abc; in_chain[1] = IV;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      n_checks += 3;
      if (out_state[1] !== DIG_EMPTY) begin n_fails++; $display("FAIL bp_hold_state cyc=%0d: got %h, required %h", i, out_state[1], DIG_EMPTY); end
      if (out_valid[1] !== 1'b1) begin n_fails++; $display("FAIL bp_hold_valid cyc=%0d: got %b, required 1", i, out_valid[1]); end
      if (in_ready[1] !== 1'b0) begin n_fails++; $display("FAIL bp_hold_ready cyc=%0d: got %b, required 0", i, in_ready[1]); end
    end
    release_out(1);
    n_checks += 2;
    if (out_valid[1] !== 1'b0) begin n_fails++; $display("FAIL bp_release_valid: got %b, required 0", out_valid[1]); end
    if (in_ready[1] !== 1'b1) begin n_fails++; $display("FAIL bp_release_ready: got %b, required 1", in_ready[1]); end
    @(posedge clk); #1;
    in_valid[1] = 1'b0; in_block[1] = '1; in_chain[1] = '1;
    n_checks++;
    if (busy[1] !== 1'b1) begin n_fails++; $display("FAIL bp_second_accept: busy=%b, required 1", busy[1]); end
    wait_out(1, lat);
    n_checks += 2;
    if (lat !== 16) begin n_fails++; $display("FAIL bp_second_latency: got %0d, required 16", lat); end
    if (out_state[1] !== DIG_ABC) begin n_fails++; $display("FAIL bp_second_digest: got %h, required %h", out_state[1], DIG_ABC); end
    release_out(1);
  endtask

  task automatic test_reset_mid_run();
    int lat;
    int seen = 0;
    send(0, blk_empty, IV);
    repeat (32) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    n_checks += 3;
    if (busy[0] !== 1'b0) begin n_fails++; $display("FAIL midrst_busy: got %b, required 0", busy[0]); end
    if (out_valid[0] !== 1'b0) begin n_fails++; $display("FAIL midrst_valid: got %b, required 0", out_valid[0]); end
    if (in_ready[0] !== 1'b0) begin n_fails++; $display("FAIL midrst_ready_in_reset: got %b, required 0", in_ready[0]); end
    reset = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (in_ready[0] !== 1'b1) begin n_fails++; $display("FAIL midrst_ready_after: got %b, required 1", in_ready[0]); end
    for (int i = 0; i < 80; i++) begin
      if (out_valid[0] !== 1'b0) seen++;
      @(posedge clk); #1;
    end
    n_checks++;
    if (seen !== 0) begin n_fails++; $display("FAIL midrst_no_output: out_valid high %0d cycles, required 0", seen); end
    send(0, blk_empty, IV);
    wait_out(0, lat);
    n_checks += 2;
    if (lat !== 64) begin n_fails++; $display("FAIL midrst_rerun_latency: got %0d, required 64", lat); end
    if (out_state[0] !== DIG_EMPTY) begin n_fails++; $display("FAIL midrst_rerun_digest: got %h, required %h", out_state[0], DIG_EMPTY); end
    release_out(0);
  endtask

  task automatic test_no_final_add();
    int lat;
    logic [127:0] exp_raw;
    for (int w = 0; w < 4; w++) exp_raw[32*w +: 32] = DIG_EMPTY[32*w +: 32] - IV[32*w +: 32];
    send(2, blk_empty, IV);
    wait_out(2, lat);
    n_checks += 2;
    if (lat !== 64) begin n_fails++; $display("FAIL nofa_latency: got %0d, required 64", lat); end
    if (out_state[2] !== exp_raw) begin n_fails++; $display("FAIL nofa_state: got %h, required %h", out_state[2], exp_raw); end
    release_out(2);
  endtask

  task automatic test_sweep();
    int ids [4] = '{0, 3, 4, 5};
    int lat;
    int id;
    logic [511:0] blk;
    logic [127:0] chn, exp_st;
    for (int t = 0; t < 4; t++) begin
      id = ids[t];
      for (int r = 0; r < 100; r++) begin
        for (int k = 0; k < 16; k++) blk[32*k +: 32] = $urandom;
        for (int k = 0; k < 4; k++) chn[32*k +: 32] = $urandom;
        exp_st = ref_md5(blk, chn, 1'b1);
        send(id, blk, chn);
        wait_out(id, lat);
        n_checks += 2;
        if (lat !== 64 / S_TAB[id]) begin n_fails++; $display("FAIL sweep_latency S=%0d run=%0d: got %0d, required %0d", S_TAB[id], r, lat, 64 / S_TAB[id]); end
        if (out_state[id] !== exp_st) begin n_fails++; $display("FAIL sweep_state S=%0d run=%0d: got %h, required %h", S_TAB[id], r, out_state[id], exp_st); end
        release_out(id);
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    for (int j = 0; j < NI; j++) begin
      in_valid[j] = 1'b0; out_ready[j] = 1'b0; in_block[j] = '0; in_chain[j] = '0;
    end
    blk_empty = '0;
    blk_empty[31:0] = 32'h00000080;
    blk_abc = '0;
    blk_abc[31:0]    = 32'h80636261;
    blk_abc[479:448] = 32'h00000018;
    test_reset();
    test_empty_s1();
    test_abc_s4();
    test_backpressure();
    test_reset_mid_run();
    test_no_final_add();
    test_sweep();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
